// File: rtl/fifo_wr_arbiter_if.sv
// Requester streams, FIFO write-side signals and grant status shared by the
// write-port arbiter and its surroundings.
interface fifo_wr_arbiter_if #(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned NREQ     = 4
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_last;
    logic [NREQ*DATASIZE-1:0] req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     wfull;
    logic                     wclken;
    logic [DATASIZE-1:0]      wdata;
    logic                     grant_valid;
    logic [IDW-1:0]           grant_id;

    // Requesters and FIFO status side
    modport master (
        output req_valid, req_last, req_data, wfull,
        input  req_ready, wclken, wdata, grant_valid, grant_id
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_last, req_data, wfull,
        output req_ready, wclken, wdata, grant_valid, grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NREQ valid/ready/last
// streams; a grant lasts one packet or at most MAXBURST beats.
module fifo_wr_arbiter #(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAXBURST = 4
) (
    input  logic             wclk,
    input  logic             wrst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int unsigned IDW  = $clog2(NREQ);
    localparam int unsigned CNTW = $clog2(MAXBURST + 1);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      grant_id_q, grant_id_d;
    logic [IDW-1:0]      last_grant_q, last_grant_d;
    logic                grant_valid_q, grant_valid_d;
    logic [CNTW-1:0]     beat_cnt_q, beat_cnt_d;

    logic [IDW-1:0]      winner;
    logic                found;
    int unsigned         rr_idx;

    logic                sel_valid, sel_last, xfer;
    logic [DATASIZE-1:0] sel_data, wr_data;
    logic [NREQ-1:0]     rdy;

    // First valid requester after last_grant, wrapping mod NREQ
    always_comb begin
        winner = '0;
        found  = 1'b0;
        rr_idx = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            rr_idx = (32'(last_grant_q) + k) % NREQ;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found && (i == rr_idx) && bus.req_valid[i]) begin
                    found  = 1'b1;
                    winner = IDW'(i);
                end
            end
        end
    end

    // Granted requester's stream
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_id_q) begin
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
                sel_data  = bus.req_data[i*DATASIZE +: DATASIZE];
            end
        end
    end

    // Next state and write-side outputs; reset masks the write path so an
    // interrupted burst leaves no partial beat behind
    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        last_grant_d  = last_grant_q;
        beat_cnt_d    = beat_cnt_q;
        rdy           = '0;
        xfer          = 1'b0;
        wr_data       = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d       = LOCKED;
                    grant_valid_d = 1'b1;
                    grant_id_d    = winner;
                    beat_cnt_d    = '0;
                end
            end
            LOCKED: begin
                if (!wrst) begin
                    wr_data = sel_data;
                    xfer    = sel_valid && !bus.wfull;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        rdy[i] = (IDW'(i) == grant_id_q) && !bus.wfull;
                    end
                end
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CNTW'(1);
                    if (sel_last || (beat_cnt_q == CNTW'(MAXBURST - 1))) begin
                        state_d       = IDLE;
                        grant_valid_d = 1'b0;
                        last_grant_d  = grant_id_q;
                        beat_cnt_d    = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q       <= IDLE;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            last_grant_q  <= IDW'(NREQ - 1);
            beat_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            last_grant_q  <= last_grant_d;
            beat_cnt_q    <= beat_cnt_d;
        end
    end

    assign bus.req_ready   = rdy;
    assign bus.wclken      = xfer;
    assign bus.wdata       = wr_data;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = grant_id_q;
endmodule
